// File: rtl/if_id_buffer.sv
// IF->ID pipeline buffer: two-entry skid FIFO with valid/ready on both sides.
// Outputs come straight from head registers; flush drops everything in flight.
module if_id_buffer #(
  parameter int WORD      = 64,
  parameter int INST_SIZE = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [WORD-1:0]      if_pc,
  input  logic [WORD-1:0]      if_pc_incr,
  input  logic [INST_SIZE-1:0] if_inst,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [WORD-1:0]      id_pc,
  output logic [WORD-1:0]      id_pc_incr,
  output logic [INST_SIZE-1:0] id_inst,
  output logic [1:0]           occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high and flush is low; ready never depends on the partner's valid.

  if (DEPTH != 2) begin : g_bad_depth
    $error("if_id_buffer supports DEPTH == 2 only");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [WORD-1:0]      pc_incr;
    logic [INST_SIZE-1:0] inst;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push, pop;

  assign if_ready = (state_q != FULL);
  assign id_valid = (state_q != EMPTY);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  assign in_entry.pc      = if_pc;
  assign in_entry.pc_incr = if_pc_incr;
  assign in_entry.inst    = if_inst;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            // Clearing the head keeps id_inst at 0 while nothing is valid.
            head_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign occupancy  = state_q;
  assign id_pc      = head_q.pc;
  assign id_pc_incr = head_q.pc_incr;
  assign id_inst    = head_q.inst;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: reference FIFO model in a queue,
// outputs compared on the falling edge against the model head.
module tb_if_id_buffer;

  localparam int WORD = 64;
  localparam int INST_SIZE = 32;
  localparam int W = 2 * WORD + INST_SIZE;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 if_valid = 1'b0;
  logic                 if_ready;
  logic [WORD-1:0]      if_pc = '0;
  logic [WORD-1:0]      if_pc_incr = '0;
  logic [INST_SIZE-1:0] if_inst = '0;
  logic                 id_valid;
  logic                 id_ready = 1'b0;
  logic [WORD-1:0]      id_pc;
  logic [WORD-1:0]      id_pc_incr;
  logic [INST_SIZE-1:0] id_inst;
  logic [1:0]           occupancy;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  if_id_buffer #(.WORD(WORD), .INST_SIZE(INST_SIZE), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc_incr(if_pc_incr), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_incr(id_pc_incr), .id_inst(id_inst),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model head (zeros when empty).
  task automatic check_outputs(input string tag);
    logic [W-1:0] head;
    int sz;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(sz));
    chk({tag, ".id_valid"},  64'(id_valid),  64'(sz != 0));
    chk({tag, ".if_ready"},  64'(if_ready),  64'(sz != 2));
    chk({tag, ".id_pc"},      id_pc,      head[W-1 -: WORD]);
    chk({tag, ".id_pc_incr"}, id_pc_incr, head[INST_SIZE +: WORD]);
    chk({tag, ".id_inst"},    64'(id_inst), 64'(head[INST_SIZE-1:0]));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, ".id_valid"},  64'(id_valid),  64'd0);
    chk({tag, ".if_ready"},  64'(if_ready),  64'd1);
    chk({tag, ".id_pc"},      id_pc,      64'd0);
    chk({tag, ".id_pc_incr"}, id_pc_incr, 64'd0);
    chk({tag, ".id_inst"},    64'(id_inst), 64'd0);
  endtask

  // driver: one clock cycle of stimulus; model updated at the rising edge
  task automatic cycle(input string tag, input logic v, input logic [WORD-1:0] pc,
                       input logic [INST_SIZE-1:0] inst, input logic rdy, input logic fl);
    int sz;
    @(negedge clk);
    check_outputs(tag);
    if_valid   = v;
    if_pc      = pc;
    if_pc_incr = pc + 64'd4;
    if_inst    = inst;
    id_ready   = rdy;
    flush      = fl;
    sz = exp_q.size();
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && rdy) void'(exp_q.pop_front());
      if (sz < 2 && v) exp_q.push_back({pc, pc + 64'd4, inst});
    end
  endtask

  initial begin
    // reset asserted from time 0; check values mid-cycle
    #3;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle("idle", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

    // streaming
    cycle("stream0", 1'b1, 64'd0, 32'd2, 1'b1, 1'b0);
    cycle("stream1", 1'b1, 64'd4, 32'd7, 1'b1, 1'b0);
    cycle("stream2", 1'b1, 64'd8, 32'd9, 1'b1, 1'b0);
    cycle("stream3", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    cycle("stream4", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // stall and fill; third push ignored, IF holds it
    cycle("stall0", 1'b1, 64'd12, 32'd31, 1'b0, 1'b0);
    cycle("stall1", 1'b1, 64'd16, 32'd15, 1'b0, 1'b0);
    cycle("stall2", 1'b1, 64'd20, 32'd16, 1'b0, 1'b0);
    cycle("stall3", 1'b1, 64'd20, 32'd16, 1'b0, 1'b0);
    cycle("drain0", 1'b1, 64'd20, 32'd16, 1'b1, 1'b0);
    cycle("drain1", 1'b1, 64'd20, 32'd16, 1'b1, 1'b0);
    cycle("drain2", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    cycle("drain3", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // flush in FULL with a simultaneous push of inst 40
    cycle("fill0", 1'b1, 64'd24, 32'd50, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 64'd28, 32'd51, 1'b0, 1'b0);
    cycle("flush", 1'b1, 64'd32, 32'd40, 1'b0, 1'b1);
    cycle("post_flush", 1'b1, 64'd36, 32'd41, 1'b1, 1'b0);
    cycle("post_flush1", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // simultaneous push and pop in ONE
    cycle("pp0", 1'b1, 64'd40, 32'd5, 1'b0, 1'b0);
    cycle("pp1", 1'b1, 64'd44, 32'd6, 1'b1, 1'b0);
    cycle("pp2", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    cycle("pp3", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // asynchronous reset while FULL and stalled
    cycle("rs0", 1'b1, 64'd48, 32'd60, 1'b0, 1'b0);
    cycle("rs1", 1'b1, 64'd52, 32'd61, 1'b0, 1'b0);
    cycle("rs2", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(negedge clk);
    if_valid = 1'b0;
    rst_n = 1'b1;
    cycle("after_rst0", 1'b1, 64'd56, 32'd3, 1'b1, 1'b0);
    cycle("after_rst1", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 64'($urandom_range(0, 1023)) << 2,
            32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    cycle("final", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs("final_drain");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
